// File: rtl/alu_nibble_seq_if.sv
// ALU-side bus of the nibble sequencer.
// The sequencer (master) drives one nibble pair, op, bank and carry-in per
// cycle; the 4-bit ALU (slave) answers combinationally with result and NZVC.
interface alu_nibble_seq_if;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic       alu_cin;
    logic       alu_bank;
    logic [3:0] alu_result;
    logic [3:0] alu_flags;

    modport master (
        output alu_a, alu_b, alu_op, alu_cin, alu_bank,
        input  alu_result, alu_flags
    );

    modport slave (
        input  alu_a, alu_b, alu_op, alu_cin, alu_bank,
        output alu_result, alu_flags
    );
endinterface

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs a 4-bit ALU once per nibble, least-significant first,
// chaining carry, to perform NIBBLES*4-bit operations. Emits a one-cycle done
// pulse with the assembled result and a combined NZVC flag set.
// Optional feature macro: ALU_SEQ_ZACC_EN -- when defined, flags[2] is the AND
// of every nibble's Z flag (whole-word zero); otherwise it is the Z flag of the
// most-significant nibble only and the Z accumulator is not built.
module alu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic                   bank,
    input  logic                   cin,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic [3:0]             flags,
    alu_nibble_seq_if.master       alu
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q,   state_d;
    logic [W-1:0]    a_q,       a_d;
    logic [W-1:0]    b_q,       b_d;
    logic [2:0]      op_q,      op_d;
    logic            bank_q,    bank_d;
    logic            carry_q,   carry_d;
    logic [IW-1:0]   idx_q,     idx_d;
    logic [W-1:0]    scratch_q, scratch_d;
    logic [W-1:0]    result_q,  result_d;
    logic [3:0]      flags_q,   flags_d;
`ifdef ALU_SEQ_ZACC_EN
    logic            zacc_q,    zacc_d;
`endif

    logic            z_final;
    logic [3:0]      a_nib [NIBBLES];
    logic [3:0]      b_nib [NIBBLES];

    // Split latched operands into nibble lanes for the per-cycle select.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_q[4*gi +: 4];
            assign b_nib[gi] = b_q[4*gi +: 4];
        end
    endgenerate

    // Z reported on completion: accumulated over all nibbles, or top nibble only.
`ifdef ALU_SEQ_ZACC_EN
    assign z_final = zacc_q & alu.alu_flags[2];
`else
    assign z_final = alu.alu_flags[2];
`endif

    // Next-state logic for the control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: operand latch on accept, nibble capture during RUN.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        bank_d    = bank_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        scratch_d = scratch_q;
        result_d  = result_q;
        flags_d   = flags_q;
`ifdef ALU_SEQ_ZACC_EN
        zacc_d    = zacc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    op_d      = op;
                    bank_d    = bank;
                    carry_d   = cin;
                    idx_d     = '0;
                    scratch_d = '0;
`ifdef ALU_SEQ_ZACC_EN
                    zacc_d    = 1'b1;
`endif
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) scratch_d[4*i +: 4] = alu.alu_result;
                end
                carry_d = alu.alu_flags[0];
`ifdef ALU_SEQ_ZACC_EN
                zacc_d  = zacc_q & alu.alu_flags[2];
`endif
                if (idx_q == LAST_IDX) begin
                    // idx holds at the last nibble; result merges the live top nibble.
                    result_d = {alu.alu_result, scratch_q[W-5:0]};
                    flags_d  = {alu.alu_flags[3], z_final,
                                alu.alu_flags[1], alu.alu_flags[0]};
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset discards any partial operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            bank_q    <= 1'b0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            scratch_q <= '0;
            result_q  <= '0;
            flags_q   <= 4'b0000;
`ifdef ALU_SEQ_ZACC_EN
            zacc_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            bank_q    <= bank_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            scratch_q <= scratch_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
`ifdef ALU_SEQ_ZACC_EN
            zacc_q    <= zacc_d;
`endif
        end
    end

    // Outputs decode from registered state only; ALU bus is zero in IDLE.
    always_comb begin
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
        result       = result_q;
        flags        = flags_q;
        alu.alu_a    = 4'h0;
        alu.alu_b    = 4'h0;
        alu.alu_op   = 3'b000;
        alu.alu_cin  = 1'b0;
        alu.alu_bank = 1'b0;
        if (state_q != ST_IDLE) begin
            alu.alu_a    = a_nib[idx_q];
            alu.alu_b    = b_nib[idx_q];
            alu.alu_op   = op_q;
            alu.alu_cin  = carry_q;
            alu.alu_bank = bank_q;
        end
    end
endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq with a 4-bit adder ALU model.
module tb_alu_nibble_seq;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic         bank;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int n_cmp = 0;
    int n_bad = 0;

    alu_nibble_seq_if alu_bus ();

    alu_nibble_seq #(.NIBBLES(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .bank   (bank),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags),
        .alu    (alu_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit ALU model: A+B+Cin with NZVC from the nibble sum.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b} + {4'b0, alu_bus.alu_cin};
        alu_bus.alu_result = alu_sum[3:0];
        alu_bus.alu_flags  = {alu_sum[3], (alu_sum[3:0] == 4'h0),
                              (alu_bus.alu_a[3] == alu_bus.alu_b[3]) && (alu_sum[3] != alu_bus.alu_a[3]),
                              alu_sum[4]};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Whole-word reference: plain W-bit addition.
    function automatic void ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                      input logic rc, output logic [W-1:0] rr,
                                      output logic [3:0] rf);
        logic [W:0] s;
        logic z;
        s  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
        rr = s[W-1:0];
`ifdef ALU_SEQ_ZACC_EN
        z  = (rr == '0);
`else
        z  = (rr[W-1:W-4] == 4'h0);
`endif
        rf = {rr[W-1], z, (ra[W-1] == rb[W-1]) && (rr[W-1] != ra[W-1]), s[W]};
    endfunction

    // Carry into nibble k = carry out of the low 4k bits of the sum.
    function automatic logic cin_at(input logic [W-1:0] ca, input logic [W-1:0] cb,
                                    input logic cc, input int k);
        logic [W:0] m;
        logic [W:0] s;
        m = ({{W{1'b0}}, 1'b1} << (4 * k)) - 1'b1;
        s = ({1'b0, ca} & m) + ({1'b0, cb} & m) + {{W{1'b0}}, cc};
        return s[4*k];
    endfunction

    // One full operation with per-cycle checks. mid_start pulses start with
    // other operands during RUN; hold_start keeps start high to test re-accept.
    task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic [2:0] top, input logic tbank,
                         input logic [W-1:0] er, input logic [3:0] ef,
                         input bit mid_start, input bit hold_start);
        int done_cnt = 0;
        int busy_cnt = 0;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; op = top; bank = tbank; start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        for (int k = 0; k < N + 2; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (k < N) begin
                chk({nm, " alu_a"},   {28'b0, alu_bus.alu_a},   {28'b0, ta[4*k +: 4]});
                chk({nm, " alu_b"},   {28'b0, alu_bus.alu_b},   {28'b0, tb_[4*k +: 4]});
                chk({nm, " alu_cin"}, {31'b0, alu_bus.alu_cin}, {31'b0, cin_at(ta, tb_, tc, k)});
                chk({nm, " alu_op"},  {28'b0, alu_bus.alu_bank, alu_bus.alu_op}, {28'b0, tbank, top});
                chk({nm, " done_early"}, {31'b0, done}, 32'd0);
            end else if (k == N) begin
                chk({nm, " done"},   {31'b0, done}, 32'd1);
                chk({nm, " result"}, {16'b0, result}, {16'b0, er});
                chk({nm, " flags"},  {28'b0, flags},  {28'b0, ef});
            end else begin
                chk({nm, " done_fall"}, {31'b0, done}, 32'd0);
                chk({nm, " idle_alu"},  {17'b0, alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_op,
                                         alu_bus.alu_cin, alu_bus.alu_bank}, 32'd0);
                chk({nm, " held"},      {12'b0, flags, result}, {12'b0, ef, er});
            end
            if (mid_start && k == 1) begin
                start = 1'b1; a = ~ta; b = ~tb_; cin = ~tc; op = ~top;
            end
            if (mid_start && k == 2) start = 1'b0;
        end
        chk({nm, " done_count"}, done_cnt, 32'd1);
        chk({nm, " busy_cycles"}, busy_cnt, N + 1);
        if (hold_start) begin
            @(negedge clk);
            chk({nm, " reaccept"}, {31'b0, busy}, 32'd1);
            start = 1'b0;
            repeat (N + 2) @(negedge clk);
        end
        $display("op %s a=%h b=%h cin=%0d -> result=%h flags=%b", nm, ta, tb_, tc, result, flags);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] r;
        logic [3:0]   f;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [W-1:0] ra, rb, rr;
        logic [3:0]   rf;
        logic         rc;
        logic [2:0]   rop;

        tbl[0] = '{a: 16'h1234, b: 16'h0FCD, cin: 1'b0, r: 16'h2201, f: 4'b0000};
        tbl[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, r: 16'h0000, f: 4'b0101};
`ifdef ALU_SEQ_ZACC_EN
        tbl[2] = '{a: 16'h00F0, b: 16'h0000, cin: 1'b0, r: 16'h00F0, f: 4'b0000};
`else
        tbl[2] = '{a: 16'h00F0, b: 16'h0000, cin: 1'b0, r: 16'h00F0, f: 4'b0100};
`endif
        tbl[3] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, r: 16'h8000, f: 4'b1010};

        rst_n = 1'b0; start = 1'b0; op = 3'b000; bank = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy_done", {30'b0, busy, done}, 32'd0);
        chk("reset result_flags", {12'b0, flags, result}, 32'd0);
        chk("reset alu", {17'b0, alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_op,
                          alu_bus.alu_cin, alu_bus.alu_bank}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, 3'b000, 1'b0,
                  tbl[i].r, tbl[i].f, 1'b0, 1'b0);

        // Start during RUN with different operands must be ignored.
        do_op("midstart", 16'h1234, 16'h0FCD, 1'b0, 3'b000, 1'b0, 16'h2201, 4'b0000, 1'b1, 1'b0);

        // Start held high is re-accepted right after DONE.
        do_op("hold", 16'h7FFF, 16'h0001, 1'b0, 3'b000, 1'b0, 16'h8000, 4'b1010, 1'b0, 1'b1);

        // Reset during nibble 2 clears everything at once.
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; cin = 1'b1; op = 3'b000; bank = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst nibble2", {28'b0, alu_bus.alu_a}, 32'h0000000B);
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy_done", {30'b0, busy, done}, 32'd0);
        chk("rst result_flags", {12'b0, flags, result}, 32'd0);
        chk("rst alu", {17'b0, alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_op,
                        alu_bus.alu_cin, alu_bus.alu_bank}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int stray = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (done || busy) stray++;
            end
            chk("rst no_done", stray, 32'd0);
        end

        // Randomized operations against the whole-word reference.
        for (int i = 0; i < 30; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            rop = 3'($urandom);
            if (i % 5 == 0) rb = -ra;
            ref_model(ra, rb, rc, rr, rf);
            do_op($sformatf("rnd%0d", i), ra, rb, rc, rop, 1'($urandom), rr, rf, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Multi-cycle sequencer that drives the 4-bit ALU once per nibble to perform N-nibble-wide operations. It latches wide operands and an operation, then presents one nibble pair per clock, least-significant first, chaining the ALU carry flag into the next pass's carry-in. It assembles the result nibbles and a combined NZVC flag set, and reports completion with a one-cycle `done` pulse. It sits between the control unit and the ALU and is the only driver of the ALU inputs.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; must be ≥ 2; operand width W = 4·NIBBLES.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a new operation; sampled only in IDLE.
- `op` input 3: ALU operation code, passed unchanged to `alu_op`.
- `bank` input 1: ALU operation bank, passed unchanged to `alu_bank`.
- `cin` input 1: carry-in for the least-significant nibble.
- `a` input W: first operand.
- `b` input W: second operand.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle completion pulse.
- `result` output W: assembled result; held until the next completion.
- `flags` output 4: NZVC, where [3]=N, [2]=Z, [1]=V, [0]=C; held until the next completion.
- `alu_a` output 4: nibble of `a` sent to the ALU.
- `alu_b` output 4: nibble of `b` sent to the ALU.
- `alu_op` output 3: operation code sent to the ALU.
- `alu_cin` output 1: carry-in sent to the ALU.
- `alu_bank` output 1: bank select sent to the ALU.
- `alu_result` input 4: ALU result, combinational and valid in the same cycle.
- `alu_flags` input 4: ALU NZVC flags, combinational and valid in the same cycle.

## Operation
- States:
  - IDLE → RUN when `start` is high.
  - RUN → DONE on the edge that captures nibble NIBBLES-1.
  - DONE → IDLE unconditionally.
- On acceptance (IDLE with `start`=1), the block latches:
  - `a`, `b`, `op`, `bank` into operand registers;
  - `cin` into the carry register;
  - nibble index `idx` ← 0;
  - Z accumulator ← 1;
  - a result scratch register ← 0.
- RUN, each cycle, drives the ALU as follows:
  - `alu_a` = a[4·idx+3 : 4·idx];
  - `alu_b` = b[4·idx+3 : 4·idx];
  - `alu_op` and `alu_bank` = latched values;
  - `alu_cin` = carry register.
- RUN, at each rising edge:
  - scratch nibble idx ← `alu_result`;
  - carry ← `alu_flags[0]`;
  - zacc ← zacc & `alu_flags[2]`;
  - idx ← idx+1.
- On the final nibble (idx = NIBBLES-1), at the same edge:
  - `result` ← full scratch value, with `alu_result` merged into the top nibble;
  - N ← `alu_flags[3]`, V ← `alu_flags[1]`, C ← `alu_flags[0]`;
  - Z per Configuration.
- DONE: `done`=1 for exactly one cycle; ALU inputs keep driving the last nibble.
- In IDLE, all `alu_*` outputs drive 0.
- `start` in RUN or DONE is ignored and not queued; operand changes after acceptance have no effect.
- `idx` never wraps: it stops at NIBBLES-1 and is reloaded on acceptance.
- Reset, at any time including mid-RUN:
  - state = IDLE, `busy`=0, `done`=0;
  - `result`=0, `flags`=4'b0000, all `alu_*`=0;
  - any partial result is discarded.

## Timing
- Acceptance edge E0 (IDLE, `start`=1).
- Nibble k is presented in the cycle after E0+k and captured at edge E(k+1), for k = 0..NIBBLES-1.
- `result`/`flags` update and `done` rises after edge E(NIBBLES); `done` falls after edge E(NIBBLES+1).
- Latency: start-to-done is NIBBLES cycles; throughput is one operation per NIBBLES+2 cycles.
- `start` held high continuously is re-accepted in the first IDLE cycle after DONE.
- `busy` rises after E0 and falls after E(NIBBLES+1).
- There is no combinational path from `start` to any output.

## Configuration
- `ALU_SEQ_ZACC_EN` defined: `flags[2]` = AND of the Z flags of all nibbles, giving a true whole-word zero test.
- `ALU_SEQ_ZACC_EN` undefined: `flags[2]` = Z of the most-significant nibble only; the zacc register is not built.

## Test plan
Bench ALU model: bank 0, op 3'b000 = A+B+Cin, with NZVC from the 4-bit sum. NIBBLES=4.
- a=16'h1234, b=16'h0FCD, cin=0, start pulse → `done` exactly 4 cycles after acceptance, `result`=16'h2201, `flags`=4'b0000, `alu_cin` sequence 0,1,1,0.
- a=16'hFFFF, b=16'h0001, cin=0 → `result`=16'h0000, C=1, Z=1 under both macro settings.
- a=16'h00F0, b=16'h0000, cin=0 → `result`=16'h00F0; Z=0 with `ALU_SEQ_ZACC_EN`, Z=1 without.
- a=16'h7FFF, b=16'h0001 → `result`=16'h8000, N=1, V=1, C=0, Z=0.
- `start` pulsed again during RUN with different operands → ignored; first result unchanged; exactly one `done` pulse; `busy` high for 5 cycles.
- `rst_n` asserted during nibble 2 of an operation → all outputs 0 immediately; after release, `done` stays low until a new `start`.
